// File: rtl/mem_write_buffer.sv
// Posted-store FIFO and load formatter sitting between the CPU datapath and data_memory.
// Optional store-to-load forwarding is compiled in when WBUF_FWD_EN is defined.
module mem_write_buffer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cpu_enable,
  input  logic             cpu_read_write,
  input  logic [31:0]      cpu_address,
  input  logic [31:0]      cpu_data_in,
  input  logic             cpu_access_size,
  input  logic             cpu_byte_s,
  output logic             cpu_stall,
  output logic [31:0]      cpu_data_out,
  output logic             cpu_data_valid,
  output logic             mem_enable,
  output logic             mem_read_write,
  output logic [31:0]      mem_address,
  output logic [31:0]      mem_data_in,
  output logic             mem_access_size,
  output logic             mem_byte_s,
  input  logic [31:0]      mem_data_out,
  output logic             wbuf_empty,
  output logic [CNT_W-1:0] wbuf_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Handshake: the CPU presents a request with cpu_enable; it is taken on the
  // next posedge unless cpu_stall is high, in which case inputs must be held.

  logic [31:0]      ent_addr [DEPTH];
  logic [31:0]      ent_data [DEPTH];
  logic             ent_size [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic             is_load;
  logic             is_store;
  logic             hazard;
  logic             fwd_ok;
  logic [31:0]      fwd_data;
  logic [PTR_W-1:0] scan_idx;
  logic             fwd;
  logic             mem_load;
  logic             load_go;
  logic             drain;
  logic             full;
  logic             push;
  logic [31:0]      load_word;

  function automatic logic [31:0] format_load(
    input logic [31:0] word,
    input logic [1:0]  lane,
    input logic        byte_acc,
    input logic        sext
  );
    logic [7:0] b;
    case (lane)
      2'b00:   b = word[31:24];
      2'b01:   b = word[23:16];
      2'b10:   b = word[15:8];
      default: b = word[7:0];
    endcase
    if (!byte_acc) begin
      format_load = word;
    end else begin
      format_load = {{24{sext & b[7]}}, b};
    end
  endfunction

  assign is_load  = cpu_enable & ~cpu_read_write;
  assign is_store = cpu_enable & cpu_read_write;

  // Scan oldest to youngest so the last match seen is the youngest store.
  always_comb begin
    hazard   = 1'b0;
    fwd_ok   = 1'b0;
    fwd_data = '0;
    scan_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = rd_ptr + PTR_W'(i);
      if ((CNT_W'(i) < count) && (ent_addr[scan_idx][31:2] == cpu_address[31:2])) begin
        hazard = 1'b1;
`ifdef WBUF_FWD_EN
        fwd_ok   = ~ent_size[scan_idx];
        fwd_data = ent_data[scan_idx];
`endif
      end
    end
  end

  assign fwd       = is_load & hazard & fwd_ok;
  assign mem_load  = is_load & ~hazard;
  assign load_go   = mem_load | fwd;
  assign drain     = (count != '0) & ~mem_load;
  assign full      = (count == CNT_W'(DEPTH));
  assign cpu_stall = (is_load & hazard & ~fwd) | (is_store & full & ~drain);
  assign push      = is_store & ~cpu_stall;
  assign load_word = fwd ? fwd_data : mem_data_out;

  // Port outputs are forced low while reset is held so an in-flight drain is dropped.
  always_comb begin
    mem_enable      = 1'b0;
    mem_read_write  = 1'b0;
    mem_address     = '0;
    mem_data_in     = '0;
    mem_access_size = 1'b0;
    if (!reset) begin
      if (mem_load) begin
        mem_enable  = 1'b1;
        mem_address = cpu_address;
      end else if (drain) begin
        mem_enable      = 1'b1;
        mem_read_write  = 1'b1;
        mem_address     = ent_addr[rd_ptr];
        mem_data_in     = ent_data[rd_ptr];
        mem_access_size = ent_size[rd_ptr];
      end
    end
  end

  assign mem_byte_s = 1'b0;
  assign wbuf_empty = (count == '0);
  assign wbuf_count = count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      cpu_data_out   <= '0;
      cpu_data_valid <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_addr[i] <= '0;
        ent_data[i] <= '0;
        ent_size[i] <= 1'b0;
      end
    end else begin
      if (push) begin
        ent_addr[wr_ptr] <= cpu_address;
        ent_data[wr_ptr] <= cpu_data_in;
        ent_size[wr_ptr] <= cpu_access_size;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (drain) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      // Push and drain together (including the full case) leave count unchanged.
      case ({push, drain})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      cpu_data_valid <= load_go;
      if (load_go) begin
        cpu_data_out <= format_load(load_word, cpu_address[1:0], cpu_access_size, cpu_byte_s);
      end
    end
  end

endmodule

// File: tb/tb_mem_write_buffer.sv
// Bench for mem_write_buffer: directed scenarios plus random traffic against a
// queue-and-memory-image reference model; honours WBUF_FWD_EN when defined.
module tb_mem_write_buffer;

  localparam int DEPTH = 4;
  localparam int CNT_W = 3;
  localparam logic [31:0] BASE = 32'h8002_0000;

  logic             clock = 1'b0;
  logic             reset;
  logic             cpu_enable;
  logic             cpu_read_write;
  logic [31:0]      cpu_address;
  logic [31:0]      cpu_data_in;
  logic             cpu_access_size;
  logic             cpu_byte_s;
  logic             cpu_stall;
  logic [31:0]      cpu_data_out;
  logic             cpu_data_valid;
  logic             mem_enable;
  logic             mem_read_write;
  logic [31:0]      mem_address;
  logic [31:0]      mem_data_in;
  logic             mem_access_size;
  logic             mem_byte_s;
  logic [31:0]      mem_data_out;
  logic             wbuf_empty;
  logic [CNT_W-1:0] wbuf_count;

  always #5 clock = ~clock;

  mem_write_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset),
    .cpu_enable(cpu_enable), .cpu_read_write(cpu_read_write),
    .cpu_address(cpu_address), .cpu_data_in(cpu_data_in),
    .cpu_access_size(cpu_access_size), .cpu_byte_s(cpu_byte_s),
    .cpu_stall(cpu_stall), .cpu_data_out(cpu_data_out), .cpu_data_valid(cpu_data_valid),
    .mem_enable(mem_enable), .mem_read_write(mem_read_write), .mem_address(mem_address),
    .mem_data_in(mem_data_in), .mem_access_size(mem_access_size), .mem_byte_s(mem_byte_s),
    .mem_data_out(mem_data_out), .wbuf_empty(wbuf_empty), .wbuf_count(wbuf_count)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        size;
  } st_t;

  logic [31:0] dmem    [256];
  logic [31:0] ref_mem [256];
  st_t         pend_q[$];
  logic [31:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [1:0] lo,
                                        input logic [31:0] data, input logic size);
    int          sh;
    logic [31:0] mask;
    if (!size) return data;
    sh   = 8 * (3 - int'(lo));
    mask = 32'hFF << sh;
    return (old & ~mask) | ((data & 32'hFF) << sh);
  endfunction

  function automatic logic [31:0] fmt(input logic [31:0] w, input logic [1:0] lo,
                                      input logic size, input logic bs);
    logic [31:0] b;
    if (!size) return w;
    b = (w >> (8 * (3 - int'(lo)))) & 32'hFF;
    if (bs && b[7]) b = b | 32'hFFFF_FF00;
    return b;
  endfunction

  // Simple data_memory stand-in: combinational read, byte lanes big-endian.
  always_comb mem_data_out = dmem[mem_address[9:2]];
  always @(posedge clock) begin
    if (mem_enable && mem_read_write)
      dmem[mem_address[9:2]] <= merge(dmem[mem_address[9:2]], mem_address[1:0],
                                      mem_data_in, mem_access_size);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock of CPU activity; called just after a posedge.
  task automatic step(input logic en, input logic rw, input logic [31:0] addr,
                      input logic [31:0] data, input logic size, input logic bs,
                      output logic stalled);
    logic is_load, is_store, hazard, fwd, mem_load, drain, e_stall;
    logic [31:0] fwd_d;
    st_t h;
    cpu_enable = en; cpu_read_write = rw; cpu_address = addr;
    cpu_data_in = data; cpu_access_size = size; cpu_byte_s = bs;
    @(negedge clock);
    is_load  = en && !rw;
    is_store = en && rw;
    hazard = 1'b0; fwd = 1'b0; fwd_d = '0;
    foreach (pend_q[i]) begin
      if (pend_q[i].addr[31:2] == addr[31:2]) begin
        hazard = 1'b1;
        fwd    = !pend_q[i].size;
        fwd_d  = pend_q[i].data;
      end
    end
`ifndef WBUF_FWD_EN
    fwd = 1'b0;
`endif
    fwd      = fwd && is_load;
    mem_load = is_load && !hazard;
    drain    = !mem_load && (pend_q.size() > 0);
    e_stall  = (is_load && hazard && !fwd) || (is_store && pend_q.size() == DEPTH && !drain);
    chk("cpu_stall", cpu_stall, e_stall);
    chk("mem_enable", mem_enable, mem_load || drain);
    if (mem_load) begin
      chk("rd_rw", mem_read_write, 0);
      chk("rd_addr", mem_address, addr);
    end else if (drain) begin
      chk("wr_rw", mem_read_write, 1);
      chk("wr_addr", mem_address, pend_q[0].addr);
      chk("wr_data", mem_data_in, pend_q[0].data);
      chk("wr_size", mem_access_size, pend_q[0].size);
    end
    chk("mem_byte_s", mem_byte_s, 0);
    if (is_load && !e_stall)
      exp_q.push_back(fmt(fwd ? fwd_d : ref_mem[addr[9:2]], addr[1:0], size, bs));
    @(posedge clock);
    #1;
    if (exp_q.size() > 0) begin
      chk("ld_valid", cpu_data_valid, 1);
      chk("ld_data", cpu_data_out, exp_q.pop_front());
    end else begin
      chk("ld_valid", cpu_data_valid, 0);
    end
    if (drain) begin
      h = pend_q.pop_front();
      ref_mem[h.addr[9:2]] = merge(ref_mem[h.addr[9:2]], h.addr[1:0], h.data, h.size);
    end
    if (is_store && !e_stall) pend_q.push_back('{addr: addr, data: data, size: size});
    chk("count", 32'(wbuf_count), pend_q.size());
    chk("empty", wbuf_empty, pend_q.size() == 0);
    stalled = e_stall;
  endtask

  // Hold a request until accepted, bounded.
  task automatic issue(input logic rw, input logic [31:0] addr, input logic [31:0] data,
                       input logic size, input logic bs, output int n_stall);
    logic st;
    n_stall = 0;
    st = 1'b1;
    for (int t = 0; t < 8 && st; t++) begin
      step(1'b1, rw, addr, data, size, bs, st);
      if (st) n_stall++;
    end
    chk("stall_bound", st, 0);
  endtask

  task automatic idle(input int n);
    logic st;
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, st);
  endtask

  int          ns;
  int          tot;
  logic [31:0] a;
  logic        sz;

  initial begin
    for (int i = 0; i < 256; i++) begin
      dmem[i] = '0;
      ref_mem[i] = '0;
    end
    reset = 1'b1;
    cpu_enable = 0; cpu_read_write = 0; cpu_address = '0;
    cpu_data_in = '0; cpu_access_size = 0; cpu_byte_s = 0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_data_out", cpu_data_out, 0);
    chk("rst_valid", cpu_data_valid, 0);
    chk("rst_mem_en", mem_enable, 0);
    chk("rst_mem_addr", mem_address, 0);
    chk("rst_count", 32'(wbuf_count), 0);
    chk("rst_empty", wbuf_empty, 1);
    reset = 1'b0;

    // Single word store drained on the following cycle.
    issue(1'b1, BASE, 32'hDEAD_BEEF, 1'b0, 1'b0, ns);
    idle(1);
    chk("deadbeef_mem", dmem[0], 32'hDEAD_BEEF);

    // Back-to-back word stores never stall.
    tot = 0;
    for (int i = 0; i < 5; i++) begin
      issue(1'b1, BASE + 32'(4 * (i + 1)), 32'h1111_0000 + 32'(i), 1'b0, 1'b0, ns);
      tot += ns;
    end
    chk("burst_stalls", tot, 0);
    idle(2);

    // Byte store then sign- and zero-extended byte loads.
    issue(1'b1, BASE + 32'h3, 32'h0000_0080, 1'b1, 1'b0, ns);
    idle(1);
    issue(1'b0, BASE + 32'h3, '0, 1'b1, 1'b1, ns);
    chk("byte_sext", cpu_data_out, 32'hFFFF_FF80);
    issue(1'b0, BASE + 32'h3, '0, 1'b1, 1'b0, ns);
    chk("byte_zext", cpu_data_out, 32'h0000_0080);

    // Load hitting a just-buffered word store.
    issue(1'b1, BASE + 32'h10, 32'h1234_5678, 1'b0, 1'b0, ns);
    issue(1'b0, BASE + 32'h10, '0, 1'b0, 1'b0, ns);
    chk("hit_data", cpu_data_out, 32'h1234_5678);
`ifdef WBUF_FWD_EN
    chk("hit_stalls", ns, 0);
`else
    chk("hit_stalls", ns, 1);
`endif
    idle(2);

    // Unrelated load while stores are pending.
    issue(1'b1, BASE + 32'h30, 32'hA0A0_A0A0, 1'b0, 1'b0, ns);
    issue(1'b1, BASE + 32'h34, 32'hB0B0_B0B0, 1'b0, 1'b0, ns);
    issue(1'b0, BASE + 32'h20, '0, 1'b0, 1'b0, ns);
    chk("unrel_stalls", ns, 0);
    idle(3);

    // Random traffic over a small address window to provoke hazards.
    for (int r = 0; r < 400; r++) begin
      sz = 1'($urandom_range(0, 1));
      a  = BASE + 32'($urandom_range(0, 15) * 4);
      if (sz) a = a + 32'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0, 1: issue(1'b1, a, $urandom, sz, 1'b0, ns);
        2:    issue(1'b0, a, '0, sz, 1'($urandom_range(0, 1)), ns);
        default: idle(1);
      endcase
    end
    for (int k = 0; k < 16 && pend_q.size() > 0; k++) idle(1);
    chk("drain_bound", pend_q.size(), 0);
    for (int i = 0; i < 256; i++) chk("mem_image", dmem[i], ref_mem[i]);

    // Reset during a drain discards the pending store.
    issue(1'b1, BASE + 32'h100, 32'hCAFE_F00D, 1'b0, 1'b0, ns);
    cpu_enable = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_mem_en", mem_enable, 0);
    chk("midrst_count", 32'(wbuf_count), 0);
    chk("midrst_empty", wbuf_empty, 1);
    pend_q.delete();
    @(posedge clock);
    #1;
    reset = 1'b0;
    idle(3);
    chk("midrst_no_write", dmem[64], ref_mem[64]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
